// File: rtl/rv64g_pkg.sv
// RV64G decode types shared by the decoder, the decode queue and issue.
// Holds the decoded record, the funct encoding and the queue entry.
package rv64g_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [5:0] {
    INVALID = 6'd0,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    ADDW, SUBW, SLLW, SRLW, SRAW,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LOAD, STORE, FENCE, ECALL, EBREAK
  } funct_t;

  typedef struct packed {
    funct_t      funct;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  width;
    logic        use_imm;
    logic [31:0] imm;
  } decoded_instr_t;

  typedef struct packed {
    decoded_instr_t    cmd;
    logic [XLEN-1:0]   pc;
    logic              illegal;
  } dq_entry_t;

endpackage

// File: rtl/instruction_decoder.sv
// Single-lane combinational RV64 integer decoder.
// Unknown encodings come out with funct == INVALID.
module instruction_decoder
  import rv64g_pkg::*;
(
  input  logic [31:0]    instr_i,
  output decoded_instr_t cmd_o
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [5:0]  f6;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];
  assign f6  = instr_i[31:26];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25],
                  instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                  instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31],
                  instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  always_comb begin
    cmd_o         = '0;
    cmd_o.funct   = INVALID;
    cmd_o.rd      = instr_i[11:7];
    cmd_o.rs1     = instr_i[19:15];
    cmd_o.rs2     = instr_i[24:20];
    cmd_o.width   = f3;
    unique case (1'b1)
      opc == OPC_OP: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: cmd_o.funct = ADD;
            3'd1: cmd_o.funct = SLL;
            3'd2: cmd_o.funct = SLT;
            3'd3: cmd_o.funct = SLTU;
            3'd4: cmd_o.funct = XOR;
            3'd5: cmd_o.funct = SRL;
            3'd6: cmd_o.funct = OR;
            default: cmd_o.funct = AND;
          endcase
        end else if (f7 == 7'h20) begin
          case (f3)
            3'd0: cmd_o.funct = SUB;
            3'd5: cmd_o.funct = SRA;
            default: cmd_o.funct = INVALID;
          endcase
        end
      end
      opc == OPC_OP_IMM: begin
        cmd_o.rs2     = '0;
        cmd_o.use_imm = 1'b1;
        cmd_o.imm     = imm_i;
        case (f3)
          3'd0: cmd_o.funct = ADD;
          3'd1: cmd_o.funct = (f6 == 6'h00) ? SLL : INVALID;
          3'd2: cmd_o.funct = SLT;
          3'd3: cmd_o.funct = SLTU;
          3'd4: cmd_o.funct = XOR;
          3'd5: cmd_o.funct = (f6 == 6'h00) ? SRL :
                              (f6 == 6'h10) ? SRA : INVALID;
          3'd6: cmd_o.funct = OR;
          default: cmd_o.funct = AND;
        endcase
      end
      opc == OPC_OP32: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: cmd_o.funct = ADDW;
            3'd1: cmd_o.funct = SLLW;
            3'd5: cmd_o.funct = SRLW;
            default: cmd_o.funct = INVALID;
          endcase
        end else if (f7 == 7'h20) begin
          case (f3)
            3'd0: cmd_o.funct = SUBW;
            3'd5: cmd_o.funct = SRAW;
            default: cmd_o.funct = INVALID;
          endcase
        end
      end
      opc == OPC_OP_IMM32: begin
        cmd_o.rs2     = '0;
        cmd_o.use_imm = 1'b1;
        cmd_o.imm     = imm_i;
        case (f3)
          3'd0: cmd_o.funct = ADDW;
          3'd1: cmd_o.funct = (f7 == 7'h00) ? SLLW : INVALID;
          3'd5: cmd_o.funct = (f7 == 7'h00) ? SRLW :
                              (f7 == 7'h20) ? SRAW : INVALID;
          default: cmd_o.funct = INVALID;
        endcase
      end
      opc == OPC_LUI: begin
        cmd_o.funct   = LUI;
        cmd_o.rs1     = '0;
        cmd_o.rs2     = '0;
        cmd_o.use_imm = 1'b1;
        cmd_o.imm     = imm_u;
      end
      opc == OPC_AUIPC: begin
        cmd_o.funct   = AUIPC;
        cmd_o.rs1     = '0;
        cmd_o.rs2     = '0;
        cmd_o.use_imm = 1'b1;
        cmd_o.imm     = imm_u;
      end
      opc == OPC_JAL: begin
        cmd_o.funct = JAL;
        cmd_o.rs1   = '0;
        cmd_o.rs2   = '0;
        cmd_o.imm   = imm_j;
      end
      opc == OPC_JALR: begin
        cmd_o.funct   = (f3 == 3'd0) ? JALR : INVALID;
        cmd_o.rs2     = '0;
        cmd_o.use_imm = 1'b1;
        cmd_o.imm     = imm_i;
      end
      opc == OPC_BRANCH: begin
        cmd_o.rd  = '0;
        cmd_o.imm = imm_b;
        case (f3)
          3'd0: cmd_o.funct = BEQ;
          3'd1: cmd_o.funct = BNE;
          3'd4: cmd_o.funct = BLT;
          3'd5: cmd_o.funct = BGE;
          3'd6: cmd_o.funct = BLTU;
          3'd7: cmd_o.funct = BGEU;
          default: cmd_o.funct = INVALID;
        endcase
      end
      opc == OPC_LOAD: begin
        cmd_o.funct   = (f3 == 3'd7) ? INVALID : LOAD;
        cmd_o.rs2     = '0;
        cmd_o.use_imm = 1'b1;
        cmd_o.imm     = imm_i;
      end
      opc == OPC_STORE: begin
        cmd_o.funct   = f3[2] ? INVALID : STORE;
        cmd_o.rd      = '0;
        cmd_o.use_imm = 1'b1;
        cmd_o.imm     = imm_s;
      end
      opc == OPC_MISC_MEM: begin
        cmd_o.funct = (f3[2:1] == 2'b00) ? FENCE : INVALID;
      end
      opc == OPC_SYSTEM: begin
        if (instr_i == 32'h0000_0073)
          cmd_o.funct = ECALL;
        else if (instr_i == 32'h0010_0073)
          cmd_o.funct = EBREAK;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Multi-lane fetch decode into an in-order circular queue.
// Accepts a full packet per cycle, issues one record per cycle.
module decode_queue #(
  parameter int FETCH_WIDTH = 2,
  parameter int DEPTH       = 8,
  parameter int XLEN        = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic                             fetch_valid_i,
  output logic                             fetch_ready_o,
  input  logic [FETCH_WIDTH-1:0][31:0]     fetch_code_i,
  input  logic [FETCH_WIDTH-1:0]           fetch_mask_i,
  input  logic [XLEN-1:0]                  fetch_pc_i,
  output logic                             dec_valid_o,
  input  logic                             dec_ready_i,
  output rv64g_pkg::decoded_instr_t        dec_cmd_o,
  output logic [XLEN-1:0]                  dec_pc_o,
  output logic                             dec_illegal_o,
  output logic [$clog2(DEPTH+1)-1:0]       count_o
);

  import rv64g_pkg::*;

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam int EPCW = rv64g_pkg::XLEN;

  logic [PTRW-1:0] head_q, head_d;
  logic [PTRW-1:0] tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;

  dq_entry_t       mem_q   [DEPTH];
  dq_entry_t       lane_ent[FETCH_WIDTH];
  decoded_instr_t  lane_cmd[FETCH_WIDTH];
  logic [PTRW-1:0] wr_idx  [FETCH_WIDTH];
  logic [CNTW-1:0] push_cnt;
  logic [CNTW:0]   free_slots;
  logic            push;
  logic            pop;
  dq_entry_t       head_ent;

  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_lane
    logic [XLEN-1:0] lane_pc;
    instruction_decoder u_dec (
      .instr_i (fetch_code_i[k]),
      .cmd_o   (lane_cmd[k])
    );
    assign lane_pc     = fetch_pc_i + (XLEN'(k) << 2);
    assign lane_ent[k] = '{
      cmd:     lane_cmd[k],
      pc:      EPCW'(lane_pc),
      illegal: (lane_cmd[k].funct == INVALID)
    };
  end

  // Prefix sum of the mask packs enabled lanes onto consecutive slots.
  always_comb begin
    push_cnt = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      wr_idx[k] = tail_q + push_cnt[PTRW-1:0];
      push_cnt  = push_cnt + CNTW'(fetch_mask_i[k]);
    end
  end

  assign free_slots    = (CNTW+1)'(DEPTH) - {1'b0, count_q};
  assign fetch_ready_o = free_slots >= (CNTW+1)'(FETCH_WIDTH);
  assign dec_valid_o   = (count_q != '0);
  assign push = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign pop  = dec_valid_o & dec_ready_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push)
        tail_d = tail_q + PTRW'(push_cnt);
      if (pop)
        head_d = head_q + PTRW'(1);
      count_d = count_q
              + (push ? push_cnt : '0)
              - CNTW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (fetch_mask_i[k])
          mem_q[wr_idx[k]] <= lane_ent[k];
      end
    end
  end

  assign head_ent      = mem_q[head_q];
  assign dec_cmd_o     = dec_valid_o ? head_ent.cmd : '0;
  assign dec_pc_o      = dec_valid_o ? XLEN'(head_ent.pc) : '0;
  assign dec_illegal_o = dec_valid_o & head_ent.illegal;
  assign count_o       = count_q;

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-instruction combinational decoder.
- Accepts a fetch packet of up to FETCH_WIDTH 32-bit instruction words per cycle and decodes every lane in parallel.
- Stores the decoded_instr_t records, each tagged with its PC and an illegal flag, in an in-order circular queue.
- Issues one decoded record per cycle to the issue stage over a valid/ready handshake.
- Sits between the fetch unit and the issue/rename stage; supports pipeline flush.

Parameters:
- FETCH_WIDTH, 2, instruction lanes per fetch packet (1..4).
- DEPTH, 8, queue entries; power of two, DEPTH >= FETCH_WIDTH.
- XLEN, 64, PC width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  discard all queued entries (branch mispredict / exception).
- fetch_valid_i  in  1  fetch packet present.
- fetch_ready_o  out  1  queue can accept a full packet this cycle.
- fetch_code_i  in  FETCH_WIDTH x 32  instruction words; lane 0 is the lowest address.
- fetch_mask_i  in  FETCH_WIDTH  per-lane valid; enabled lanes are not required to be contiguous.
- fetch_pc_i  in  XLEN  PC of lane 0.
- dec_valid_o  out  1  head entry valid.
- dec_ready_i  in  1  consumer takes head.
- dec_cmd_o  out  decoded_instr_t  head decoded instruction.
- dec_pc_o  out  XLEN  head PC.
- dec_illegal_o  out  1  head decodes to funct == INVALID.
- count_o  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (rst_i high at an edge):
  - Head and tail pointers and count go to 0.
  - dec_valid_o = 0, count_o = 0, fetch_ready_o = 1.
  - dec_cmd_o, dec_pc_o and dec_illegal_o are 0 (storage is not cleared; outputs are gated by valid).
- rst_i takes priority over flush_i, push and pop.
- fetch_ready_o = (DEPTH - count) >= FETCH_WIDTH.
  - It uses count before the same-cycle pop. This is conservative and has no combinational path from dec_ready_i.
- Push occurs when fetch_valid_i & fetch_ready_o & ~flush_i.
  - Every lane k with fetch_mask_i[k] = 1 is decoded combinationally by its own decoder instance.
  - Enabled lanes are compacted in ascending lane order and written to tail, tail+1, and so on.
  - PC of lane k = fetch_pc_i + 4*k, computed modulo 2^XLEN.
  - illegal = (cmd.funct == INVALID).
  - tail advances by popcount(fetch_mask_i).
  - A push with a mask of all zeros is accepted and stores nothing.
- Pop occurs when dec_valid_o & dec_ready_i; head advances by 1.
- Push and pop in the same cycle:
  - Both take effect.
  - count_next = count + popcount(mask) - 1.
- Latency:
  - A packet accepted at edge N shows its first entry on dec_* during cycle N+1.
  - There is no bypass from the fetch inputs to the dec_* outputs.
- Outputs dec_* are a combinational read of storage[head]. dec_valid_o = (count != 0).
- dec_* must stay stable while dec_valid_o & ~dec_ready_i.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - Full and empty are distinguished by count only.
  - A multi-lane write that straddles the wrap boundary must land in indices DEPTH-1, 0, and so on.
- Flush (flush_i high at an edge, rst_i low):
  - head = tail = count = 0.
  - Any same-cycle push and pop are ignored.
  - dec_valid_o = 0 in the next cycle.
  - fetch_ready_o stays combinational on count and is therefore 1 after the flush.
- Illegal entries are queued and issued like any other entry. The queue never drops or reorders them.

Decomposition:
- rv64g_pkg holds decoded_instr_t and the INVALID funct value (both already exist).
- Add to rv64g_pkg a packed dq_entry_t = {decoded_instr_t cmd; logic [XLEN-1:0] pc; logic illegal}, using XLEN from the package constant.
- Sub-module: instruction_decoder, instantiated FETCH_WIDTH times in a generate loop, one per lane.
- Lane compaction is a prefix sum of fetch_mask_i, kept inside decode_queue.

Test Plan:
- Reset, then FETCH_WIDTH=2 push of {0x00500093 (addi x1,x0,5), 0x00000013 (nop)}, mask=2'b11, pc=0x1000, dec_ready_i=1:
  - Cycle N+1: dec_pc_o=0x1000, illegal=0.
  - Cycle N+2: dec_pc_o=0x1004.
  - count_o sequence 2,1,0.
- Fill to full with dec_ready_i=0: four pushes of mask 11 → count_o=8, fetch_ready_o=0, and a further fetch_valid_i is not accepted.
  - One pop then gives count 7, fetch_ready_o still 0.
  - Two pops then give count 6, fetch_ready_o=1.
- Sparse mask 2'b10, code lane1 = 0x00000000, pc=0x2000 → one entry with dec_pc_o=0x2004, dec_illegal_o=1.
- Wrap: with head=tail=7 and count=0, push mask 11 → entries land at index 7 then 0.
  - Both pop in order with correct PCs; count returns to 0.
- Simultaneous push (mask 11) and pop at count=3 → count_o=4 next cycle, order preserved.
- flush_i asserted together with fetch_valid_i and count=5 → next cycle count_o=0, dec_valid_o=0, and the flushed-cycle packet is absent.
  - A rst_i pulse mid-stream gives the same result.
